trace_replay_engine: RTL and testbench
======================================

Name: trace_replay_engine

Overview:
- Synthesizable trace-replay and statistics engine for the cache simulator.
- Fetches reference addresses from an external trace memory and presents each one to the cache using the two-phase search/update protocol (cache_state 0 = search, 1 = update).
- Counts references and hits in saturating counters and flags completion.
- Generalises fixed-size trace replay with a runtime trace length, parametrised widths, abort, and restart.

Parameters:
- ADDR_W, 32: width of a cache reference address (one trace word).
- TRACE_AW, 16: trace memory index width; maximum trace length is 2**TRACE_AW - 1.
- CNT_W, 16: width of the reference/hit/miss counters; all three saturate.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run; honoured only in IDLE or DONE.
- abort  in  1  ends a run early; honoured in FETCH/SEARCH/UPDATE.
- trace_len  in  TRACE_AW  number of references to replay; sampled on accepted start.
- mem_addr  out  TRACE_AW  trace memory index.
- mem_rdata  in  ADDR_W  trace word; valid exactly one cycle after mem_addr changes.
- cache_addr  out  ADDR_W  reference address presented to the cache.
- cache_state  out  1  0 = search phase, 1 = update phase.
- cache_hit  in  1  hit indication from the cache; sampled in UPDATE.
- ref_count  out  CNT_W  references completed.
- hit_count  out  CNT_W  hits observed.
- miss_count  out  CNT_W  ref_count - hit_count (combinational).
- busy  out  1  high in FETCH, SEARCH, UPDATE.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, rst high):
  - State IDLE.
  - mem_addr, cache_addr, ref_count, hit_count = 0.
  - cache_state = 0, busy = 0, done = 0.
  - Internal index and latched length = 0.
- FSM states: IDLE, FETCH, SEARCH, UPDATE, DONE. All registered, one cycle per state.
- IDLE / DONE + start:
  - Latch trace_len; clear index, ref_count and hit_count; mem_addr <= 0.
  - Go to FETCH, or to DONE directly if trace_len == 0 (counters cleared, done remains/becomes 1).
- FETCH:
  - mem_addr holds the index; the memory returns data.
  - Next: SEARCH, with cache_addr <= mem_rdata and cache_state <= 0.
- SEARCH:
  - Cache performs its lookup.
  - Next: UPDATE, with cache_state <= 1.
- UPDATE:
  - On the closing edge: ref_count += 1, and hit_count += 1 if cache_hit == 1. Both saturate at 2**CNT_W - 1.
  - If index == latched_len - 1: go to DONE, cache_state <= 0.
  - Else: index += 1, mem_addr <= index + 1, cache_state <= 0, go to FETCH.
- Throughput: exactly 3 cycles per reference. A trace of N references finishes 3N cycles after start is accepted, with done rising on cycle 3N+1.
- DONE:
  - Counters hold; cache_addr holds the last reference.
  - A new start restarts the run (counters cleared).
- abort:
  - Honoured in FETCH/SEARCH/UPDATE; go to DONE on the next edge.
  - If asserted in UPDATE, that reference is still counted. In FETCH or SEARCH, the in-flight reference is not counted.
  - cache_state <= 0.
  - abort has priority over the UPDATE → FETCH transition.
- start while busy: ignored.
- start and abort together in IDLE/DONE: start wins.
- trace_len changes mid-run: no effect (latched value is used).
- Counter saturation: once a counter reaches its maximum it holds. miss_count never underflows because hit_count ≤ ref_count.
- Reset mid-run: immediate return to IDLE with all outputs at reset values. The cache sees cache_state = 0.

Decomposition:
- Shared package trace_pkg:
  - State encoding constants: IDLE = 0, FETCH = 1, SEARCH = 2, UPDATE = 3, DONE = 4.
  - Default widths for ADDR_W, TRACE_AW and CNT_W.
- One sub-module, sat_counter (parametrised CNT_W, with clear and increment enable and async reset), instantiated twice for ref_count and hit_count.

Test Plan:
- Trace of 4 entries [0x10, 0x20, 0x10, 0x20], behavioural direct-mapped cache model; start with trace_len = 4.
  → cache_addr sequence 0x10, 0x20, 0x10, 0x20; ref_count = 4, hit_count = 2, miss_count = 2.
  → done rises 13 cycles after start.
- trace_len = 0, start.
  → next cycle: done = 1, busy = 0, all counters 0, no cache_state = 1 pulse.
- Start with trace_len = 8, abort asserted in the 2nd UPDATE cycle.
  → DONE with ref_count = 2; a further start with trace_len = 1 clears counters, giving ref_count = 1.
- CNT_W = 3, trace of 10 always-hit references.
  → ref_count = 7 and hit_count = 7 (saturated), miss_count = 0.
- rst asserted asynchronously mid-SEARCH.
  → same cycle: busy = 0, cache_state = 0, counters 0.
  → after release with no start, the engine stays IDLE.
- start pulsed again while busy in a 3-entry run.
  → ignored; run completes with ref_count = 3.

Source files
------------

// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
//   Shared definitions for the trace replay engine: default widths and the
//   FSM state encoding used by trace_replay_engine.
// -----------------------------------------------------------------------------
package trace_pkg;

   // Default widths
   localparam int ADDR_W_DEF   = 32;  // one trace word / cache reference address
   localparam int TRACE_AW_DEF = 16;  // trace memory index width
   localparam int CNT_W_DEF    = 16;  // statistics counter width

   // FSM state encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_SEARCH = 3'd2;
   localparam logic [2:0] ST_UPDATE = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter with synchronous clear and increment enable.
//   Once the count reaches all-ones it holds until cleared or reset.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst    in   1      asynchronous, active-high reset (count -> 0)
//   clr    in   1      synchronous clear; wins over inc
//   inc    in   1      increment enable
//   count  out  CNT_W  current count
// -----------------------------------------------------------------------------
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_ONE;
      end
   end

endmodule

// File: rtl/trace_replay_engine.sv
// -----------------------------------------------------------------------------
// trace_replay_engine
//   Replays a trace of reference addresses held in an external memory into a
//   cache using the two-phase search/update protocol, counting references and
//   hits. Each reference takes exactly three cycles: FETCH, SEARCH, UPDATE.
//
// Ports:
//   clk          in   1         system clock, rising edge
//   rst          in   1         asynchronous, active-high reset
//   start        in   1         begin a run (honoured in IDLE / DONE only)
//   abort        in   1         end a run early (honoured in FETCH/SEARCH/UPDATE)
//   trace_len    in   TRACE_AW  references to replay, sampled on accepted start
//   mem_addr     out  TRACE_AW  trace memory index
//   mem_rdata    in   ADDR_W    trace word, valid one cycle after mem_addr changes
//   cache_addr   out  ADDR_W    reference address presented to the cache
//   cache_state  out  1         0 = search phase, 1 = update phase
//   cache_hit    in   1         cache hit indication, sampled in UPDATE
//   ref_count    out  CNT_W     references completed (saturating)
//   hit_count    out  CNT_W     hits observed (saturating)
//   miss_count   out  CNT_W     ref_count - hit_count
//   busy         out  1         high in FETCH, SEARCH, UPDATE
//   done         out  1         high in DONE
// -----------------------------------------------------------------------------
module trace_replay_engine
   import trace_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int TRACE_AW = TRACE_AW_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic [TRACE_AW-1:0] trace_len,
   output logic [TRACE_AW-1:0] mem_addr,
   input  logic [ADDR_W-1:0]   mem_rdata,
   output logic [ADDR_W-1:0]   cache_addr,
   output logic                cache_state,
   input  logic                cache_hit,
   output logic [CNT_W-1:0]    ref_count,
   output logic [CNT_W-1:0]    hit_count,
   output logic [CNT_W-1:0]    miss_count,
   output logic                busy,
   output logic                done
);

   localparam logic [TRACE_AW-1:0] IDX_ONE = {{(TRACE_AW-1){1'b0}}, 1'b1};

   logic [2:0]          state;
   logic [TRACE_AW-1:0] index;
   logic [TRACE_AW-1:0] len;

   logic idle_or_done;
   logic accept;
   logic last_ref;
   logic in_update;

   assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);
   assign busy         = (state == ST_FETCH) || (state == ST_SEARCH) || (state == ST_UPDATE);
   assign done         = (state == ST_DONE);
   assign accept       = start && idle_or_done;
   assign last_ref     = (index == (len - IDX_ONE));
   assign in_update    = (state == ST_UPDATE);

   // A reference is counted on the closing edge of UPDATE, including when
   // abort is asserted in that cycle; a new accepted start clears the counts.
   sat_counter #(.CNT_W(CNT_W)) u_ref_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (accept),
      .inc   (in_update),
      .count (ref_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (accept),
      .inc   (in_update && cache_hit),
      .count (hit_count)
   );

   // hit_count never exceeds ref_count: both saturate at the same value and
   // hits only ever increment alongside references.
   assign miss_count = ref_count - hit_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         index       <= '0;
         len         <= '0;
         mem_addr    <= '0;
         cache_addr  <= '0;
         cache_state <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               // start beats abort here; abort is meaningless outside a run.
               if (start) begin
                  len      <= trace_len;
                  index    <= '0;
                  mem_addr <= '0;
                  state    <= (trace_len == '0) ? ST_DONE : ST_FETCH;
               end
            end

            ST_FETCH: begin
               if (abort) begin
                  cache_state <= 1'b0;
                  state       <= ST_DONE;
               end else begin
                  cache_addr  <= mem_rdata;
                  cache_state <= 1'b0;
                  state       <= ST_SEARCH;
               end
            end

            ST_SEARCH: begin
               if (abort) begin
                  cache_state <= 1'b0;
                  state       <= ST_DONE;
               end else begin
                  cache_state <= 1'b1;
                  state       <= ST_UPDATE;
               end
            end

            ST_UPDATE: begin
               cache_state <= 1'b0;
               if (abort || last_ref) begin
                  state <= ST_DONE;
               end else begin
                  index    <= index + IDX_ONE;
                  mem_addr <= index + IDX_ONE;
                  state    <= ST_FETCH;
               end
            end

            // NOTE: a default arm gives every encoding a defined successor so
            // unused codes recover to IDLE instead of locking up.
            default: begin
               cache_state <= 1'b0;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trace_replay_engine.sv
// -----------------------------------------------------------------------------
// tb_trace_replay_engine
//   Self-checking bench for trace_replay_engine. A default-width instance is
//   driven by a behavioural trace memory and a 4-line direct-mapped cache; a
//   second instance with CNT_W = 3 and an always-hit cache covers saturation.
// -----------------------------------------------------------------------------
module tb_trace_replay_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, abort;
   logic [15:0] trace_len;
   logic [15:0] mem_addr;
   logic [31:0] mem_rdata;
   logic [31:0] cache_addr;
   logic        cache_state;
   logic        cache_hit;
   logic [15:0] ref_count, hit_count, miss_count;
   logic        busy, done;

   // small-counter instance
   logic        s_start;
   logic [15:0] s_trace_len;
   logic [15:0] s_mem_addr;
   logic [31:0] s_mem_rdata;
   logic [31:0] s_cache_addr;
   logic        s_cache_state;
   logic [2:0]  s_ref_count, s_hit_count, s_miss_count;
   logic        s_busy, s_done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] trace_mem [0:255];
   logic [31:0] seen_q [$];

   always #5 clk = ~clk;

   trace_replay_engine dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .trace_len(trace_len),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .cache_addr(cache_addr),
      .cache_state(cache_state), .cache_hit(cache_hit), .ref_count(ref_count),
      .hit_count(hit_count), .miss_count(miss_count), .busy(busy), .done(done)
   );

   trace_replay_engine #(.ADDR_W(32), .TRACE_AW(16), .CNT_W(3)) dut_s (
      .clk(clk), .rst(rst), .start(s_start), .abort(1'b0), .trace_len(s_trace_len),
      .mem_addr(s_mem_addr), .mem_rdata(s_mem_rdata), .cache_addr(s_cache_addr),
      .cache_state(s_cache_state), .cache_hit(1'b1), .ref_count(s_ref_count),
      .hit_count(s_hit_count), .miss_count(s_miss_count), .busy(s_busy), .done(s_done)
   );

   // Trace memory: data for the current index is available within the cycle.
   assign mem_rdata   = trace_mem[mem_addr[7:0]];
   assign s_mem_rdata = trace_mem[s_mem_addr[7:0]];

   // Direct-mapped cache, 4 lines of 16 bytes: line = addr[5:4], tag = addr[31:6].
   // Flushed whenever a run is accepted, so each run starts cold.
   logic [3:0]  c_valid;
   logic [25:0] c_tag [0:3];

   assign cache_hit = cache_state && c_valid[cache_addr[5:4]] &&
                      (c_tag[cache_addr[5:4]] == cache_addr[31:6]);

   always @(posedge clk) begin
      if (start && !busy) begin
         c_valid <= '0;
      end else if (cache_state) begin
         c_valid[cache_addr[5:4]] <= 1'b1;
         c_tag[cache_addr[5:4]]   <= cache_addr[31:6];
      end
   end

   // Reference: hits in the first n trace words of a cold cache, by arithmetic.
   function automatic int model_hits(input int n);
      int    line_tag [4];
      bit    line_ok  [4];
      int    hits = 0;
      for (int i = 0; i < 4; i++) line_ok[i] = 0;
      for (int i = 0; i < n; i++) begin
         int a    = int'(trace_mem[i]);
         int line = (a / 16) % 4;
         int tg   = a / 64;
         if (line_ok[line] && line_tag[line] == tg) hits++;
         line_ok[line]  = 1;
         line_tag[line] = tg;
      end
      return hits;
   endfunction

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++)
         trace_mem[i] = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 3) << 4);
   endtask

   task automatic start_run(input int len);
      @(negedge clk);
      start     = 1'b1;
      trace_len = 16'(len);
      @(negedge clk);
      start     = 1'b0;
   endtask

   // Counts negedges after the start-release negedge until done; records the
   // address shown in every update phase.
   task automatic run_until_done(input int budget, output int edges, output bit timed_out);
      edges     = 0;
      timed_out = 1'b0;
      seen_q.delete();
      while (1) begin
         @(negedge clk);
         edges++;
         if (cache_state) seen_q.push_back(cache_addr);
         if (done) break;
         if (edges >= budget) begin
            timed_out = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_run(input string name, input int n, input int edges, input bit to);
      int exp_hits = model_hits(n);
      n_checks++;
      if (to) begin
         n_fail++;
         $display("FAIL %s timeout: done not seen after %0d cycles", name, edges);
      end
      n_checks++;
      if (edges != 3 * n) begin
         n_fail++;
         $display("FAIL %s latency: got %0d cycles, expected %0d", name, edges, 3 * n);
      end
      n_checks++;
      if (seen_q.size() != n) begin
         n_fail++;
         $display("FAIL %s ref_seq_len: got %0d, expected %0d", name, seen_q.size(), n);
      end else begin
         for (int i = 0; i < n; i++) begin
            n_checks++;
            if (seen_q[i] !== trace_mem[i]) begin
               n_fail++;
               $display("FAIL %s cache_addr[%0d]: got %h, expected %h", name, i, seen_q[i], trace_mem[i]);
            end
         end
      end
      n_checks++;
      if (ref_count !== 16'(n) || hit_count !== 16'(exp_hits) || miss_count !== 16'(n - exp_hits)) begin
         n_fail++;
         $display("FAIL %s counts: got ref=%0d hit=%0d miss=%0d, expected ref=%0d hit=%0d miss=%0d",
                  name, ref_count, hit_count, miss_count, n, exp_hits, n - exp_hits);
      end
      n_checks++;
      if (busy !== 1'b0 || cache_state !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done_flags: got busy=%b cache_state=%b, expected 0 0", name, busy, cache_state);
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if ({busy, done, cache_state, s_busy, s_done} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got busy=%b done=%b cs=%b, expected 0", busy, done, cache_state);
      end
      n_checks++;
      if ({ref_count, hit_count, miss_count, mem_addr} !== 64'd0 || cache_addr !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_values: got ref=%0d hit=%0d miss=%0d mem_addr=%0d cache_addr=%h, expected 0",
                  ref_count, hit_count, miss_count, mem_addr, cache_addr);
      end
   endtask

   task automatic test_basic();
      int edges; bit to;
      trace_mem[0] = 32'h10; trace_mem[1] = 32'h20;
      trace_mem[2] = 32'h10; trace_mem[3] = 32'h20;
      start_run(4);
      run_until_done(100, edges, to);
      check_run("basic", 4, edges, to);
      n_checks++;
      if (hit_count !== 16'd2 || miss_count !== 16'd2) begin
         n_fail++;
         $display("FAIL basic_hits: got hit=%0d miss=%0d, expected 2 2", hit_count, miss_count);
      end
   endtask

   task automatic test_zero_len();
      start_run(0);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || ref_count !== 16'd0 || hit_count !== 16'd0 || miss_count !== 16'd0) begin
         n_fail++;
         $display("FAIL zero_len: got done=%b busy=%b ref=%0d hit=%0d, expected 1 0 0 0",
                  done, busy, ref_count, hit_count);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (cache_state !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_len_hold: got cs=%b done=%b, expected 0 1", cache_state, done);
         end
      end
   endtask

   task automatic abort_at(input string name, input int len, input int k, input int phase);
      int exp_refs = (phase == 2) ? k : k - 1;
      int exp_hits;
      start_run(len);
      // After start release the engine is in FETCH of reference 1.
      for (int i = 0; i < (k - 1) * 3 + phase; i++) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      exp_hits = model_hits(exp_refs);
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || cache_state !== 1'b0) begin
         n_fail++;
         $display("FAIL %s state: got done=%b busy=%b cs=%b, expected 1 0 0", name, done, busy, cache_state);
      end
      n_checks++;
      if (ref_count !== 16'(exp_refs) || hit_count !== 16'(exp_hits)) begin
         n_fail++;
         $display("FAIL %s counts: got ref=%0d hit=%0d, expected ref=%0d hit=%0d",
                  name, ref_count, hit_count, exp_refs, exp_hits);
      end
   endtask

   task automatic test_abort();
      int edges; bit to;
      fill_random(8);
      abort_at("abort_update2", 8, 2, 2);
      // Counters hold in DONE.
      repeat (3) @(negedge clk);
      n_checks++;
      if (ref_count !== 16'd2) begin
         n_fail++;
         $display("FAIL abort_hold: got ref=%0d, expected 2", ref_count);
      end
      start_run(1);
      run_until_done(20, edges, to);
      check_run("restart_len1", 1, edges, to);
      for (int r = 0; r < 6; r++) begin
         fill_random(6);
         abort_at("abort_rand", 6, $urandom_range(1, 5), $urandom_range(0, 2));
      end
   endtask

   task automatic test_random();
      int edges; bit to; int n;
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(1, 24);
         fill_random(n);
         start_run(n);
         trace_len = 16'($urandom);  // must not affect the run in flight
         run_until_done(200, edges, to);
         check_run("random", n, edges, to);
      end
   endtask

   task automatic test_saturation();
      int edges = 0;
      for (int i = 0; i < 10; i++) trace_mem[i] = 32'(i * 64);
      @(negedge clk);
      s_start     = 1'b1;
      s_trace_len = 16'd10;
      @(negedge clk);
      s_start     = 1'b0;
      while (!s_done && edges < 100) begin
         @(negedge clk);
         edges++;
      end
      n_checks++;
      if (s_done !== 1'b1 || edges != 30) begin
         n_fail++;
         $display("FAIL sat_latency: got done=%b after %0d cycles, expected 1 after 30", s_done, edges);
      end
      n_checks++;
      if (s_ref_count !== 3'd7 || s_hit_count !== 3'd7 || s_miss_count !== 3'd0) begin
         n_fail++;
         $display("FAIL sat_counts: got ref=%0d hit=%0d miss=%0d, expected 7 7 0",
                  s_ref_count, s_hit_count, s_miss_count);
      end
   endtask

   task automatic test_start_while_busy();
      int edges = 0;
      fill_random(3);
      start_run(3);
      while (edges < 60) begin
         @(negedge clk);
         edges++;
         start     = (edges == 4);
         trace_len = (edges == 4) ? 16'd7 : 16'd3;
         if (done) break;
      end
      start = 1'b0;
      n_checks++;
      if (done !== 1'b1 || edges != 9 || ref_count !== 16'd3 || hit_count !== 16'(model_hits(3))) begin
         n_fail++;
         $display("FAIL start_busy: got done=%b cycles=%0d ref=%0d hit=%0d, expected 1 9 3 %0d",
                  done, edges, ref_count, hit_count, model_hits(3));
      end
   endtask

   task automatic test_reset_mid();
      fill_random(4);
      start_run(4);
      repeat (4) @(negedge clk);  // SEARCH of reference 2, one reference counted
      n_checks++;
      if (ref_count !== 16'd1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_pre: got ref=%0d busy=%b, expected 1 1", ref_count, busy);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || cache_state !== 1'b0 || ref_count !== 16'd0 ||
          hit_count !== 16'd0 || mem_addr !== 16'd0 || cache_addr !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got busy=%b done=%b cs=%b ref=%0d hit=%0d mem_addr=%0d, expected all 0",
                  busy, done, cache_state, ref_count, hit_count, mem_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || ref_count !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b done=%b ref=%0d, expected 0 0 0", busy, done, ref_count);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; trace_len = '0;
      s_start = 1'b0; s_trace_len = '0;
      for (int i = 0; i < 256; i++) trace_mem[i] = '0;
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      test_basic();
      test_zero_len();
      test_abort();
      test_random();
      test_saturation();
      test_start_while_busy();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
